// File: rtl/mem_stage.sv
// RV64 memory-access stage: runs one load/store per instruction over a
// req/ack data port, aligns load data and feeds write-back and forwarding.
module mem_stage #(
  parameter int PC_WD      = 64,
  parameter int RF_DATA_WD = 64,
  parameter int RF_ADDR_WD = 5,
  localparam int ES_WD  = 5 + 2 * RF_DATA_WD + 1 + RF_ADDR_WD + PC_WD,
  localparam int WS_WD  = 1 + RF_ADDR_WD + RF_DATA_WD + PC_WD,
  localparam int FWD_WD = 2 + RF_DATA_WD + RF_ADDR_WD,
  localparam int STB_WD = RF_DATA_WD / 8
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  ms_allowin,
  input  logic                  es_to_ms_valid,
  input  logic [ES_WD-1:0]      es_to_ms_bus,
  output logic                  ms_to_ws_valid,
  input  logic                  ws_allowin,
  output logic [WS_WD-1:0]      ms_to_ws_bus,
  output logic                  data_req,
  output logic                  data_wr,
  output logic [RF_DATA_WD-1:0] data_addr,
  output logic [RF_DATA_WD-1:0] data_wdata,
  output logic [STB_WD-1:0]     data_wstrb,
  input  logic                  data_addr_ok,
  input  logic                  data_rvalid,
  input  logic [RF_DATA_WD-1:0] data_rdata,
  output logic [FWD_WD-1:0]     ms_forward_bus
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DONE
  } state_e;

  state_e                  state_q, state_d;
  logic                    ms_valid_q;
  logic [ES_WD-1:0]        bus_q;
  logic [RF_DATA_WD-1:0]   res_q, res_d;

  logic                    mem_re, mem_we, mem_uns, rf_we;
  logic [1:0]              mem_size;
  logic [RF_DATA_WD-1:0]   mem_wdata, alu_res;
  logic [RF_ADDR_WD-1:0]   rd;
  logic [PC_WD-1:0]        pc;

  assign {mem_re, mem_we, mem_size, mem_uns,
          mem_wdata, alu_res, rf_we, rd, pc} = bus_q;

  logic ms_ready_go, accept, es_memop;
  logic fwd_valid, fwd_pending;
  logic [5:0]            sh;
  logic [RF_DATA_WD-1:0] rdata_sh, ld_data, result;
  logic [STB_WD-1:0]     strb_base;

  // Mem ops are launched from the accepting edge, so IDLE only ever
  // holds a non-memory instruction, which is always ready.
  assign ms_ready_go = (state_q == IDLE) || (state_q == DONE);
  assign ms_allowin  = !ms_valid_q || (ms_ready_go && ws_allowin);
  assign accept      = es_to_ms_valid && ms_allowin;
  assign es_memop    = es_to_ms_bus[ES_WD-1] | es_to_ms_bus[ES_WD-2];

  assign ms_to_ws_valid = ms_valid_q && ms_ready_go;

  assign sh       = {alu_res[2:0], 3'b000};
  assign rdata_sh = data_rdata >> sh;

  always_comb begin
    ld_data = rdata_sh;
    unique case (mem_size)
      2'd0: ld_data = {{(RF_DATA_WD-8){!mem_uns & rdata_sh[7]}},
                       rdata_sh[7:0]};
      2'd1: ld_data = {{(RF_DATA_WD-16){!mem_uns & rdata_sh[15]}},
                       rdata_sh[15:0]};
      2'd2: ld_data = {{(RF_DATA_WD-32){!mem_uns & rdata_sh[31]}},
                       rdata_sh[31:0]};
      2'd3: ld_data = rdata_sh;
      default: ld_data = rdata_sh;
    endcase
  end

  always_comb begin
    strb_base = '1;
    unique case (mem_size)
      2'd0: strb_base = STB_WD'(8'h01);
      2'd1: strb_base = STB_WD'(8'h03);
      2'd2: strb_base = STB_WD'(8'h0F);
      2'd3: strb_base = STB_WD'(8'hFF);
      default: strb_base = '1;
    endcase
  end

  assign data_req   = (state_q == REQ);
  assign data_wr    = mem_we;
  assign data_addr  = alu_res;
  assign data_wdata = mem_wdata << sh;
  assign data_wstrb = strb_base << alu_res[2:0];

  always_comb begin
    state_d = state_q;
    res_d   = res_q;
    unique case (state_q)
      IDLE: if (accept && es_memop) state_d = REQ;
      REQ:  if (data_addr_ok) state_d = WAIT;
      WAIT: begin
        if (data_rvalid) begin
          state_d = DONE;
          res_d   = mem_re ? ld_data : alu_res;
        end
      end
      DONE: begin
        if (ws_allowin) state_d = (accept && es_memop) ? REQ : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      ms_valid_q <= 1'b0;
      bus_q      <= '0;
      res_q      <= '0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      if (ms_allowin) ms_valid_q <= es_to_ms_valid;
      if (accept) bus_q <= es_to_ms_bus;
    end
  end

  assign result       = (state_q == DONE) ? res_q : alu_res;
  assign ms_to_ws_bus = {rf_we, rd, result, pc};

  assign fwd_valid      = ms_valid_q && rf_we;
  assign fwd_pending    = fwd_valid && mem_re && (state_q != DONE);
  assign ms_forward_bus = {fwd_valid, fwd_pending, result, rd};

endmodule
